// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run-control sequencer: state encoding,
// per-program base addresses and default widths.
package run_seq_pkg;

  localparam int PC_W_DEF  = 10;
  localparam int CNT_W_DEF = 16;
  localparam int SEL_W_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } run_state_t;

  localparam logic [PC_W_DEF-1:0] PROG_BASE [2**SEL_W_DEF] = '{
    10'd0, 10'd128, 10'd256, 10'd384
  };

  // Programs beyond the table continue the 128-word stride.
  function automatic logic [31:0] prog_base(input logic [31:0] sel);
    if (sel < 32'(2**SEL_W_DEF))
      return 32'(PROG_BASE[sel[SEL_W_DEF-1:0]]);
    return sel << 7;
  endfunction

endpackage

// File: rtl/run_seq_cycle_counter.sv
// Clearable, enabled up-counter with optional saturation at all-ones.
// Clear wins over enable so a relaunch always restarts from zero.
module cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             saturate,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge Clk) begin
    if (Reset || clear)
      count <= '0;
    else if (enable && !(saturate && (&count)))
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/run_sequencer.sv
// Run-control FSM for the single-cycle core: turns the Start/Ack handshake
// into PC load, run enable and done acknowledge, with a RUN-cycle watchdog.
//
//   state    | meaning
//   IDLE     | out of reset, nothing launched yet
//   ARMED    | Start held; PC loaded with selected program base
//   RUN      | core executing, cycle counter running
//   DONE     | program finished (CoreDone or watchdog); Ack high
module run_sequencer
  import run_seq_pkg::*;
#(
  parameter int          PC_W    = PC_W_DEF,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int          SEL_W   = SEL_W_DEF,
  parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [SEL_W-1:0] ProgSel,
  input  logic             CoreDone,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcLoadVal,
  output logic             RunEn,
  output logic             Ack,
  output logic             TimedOut,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [CNT_W-1:0] TIMEOUT_T = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST   = TIMEOUT_T - CNT_W'(1);
  localparam bit               WD_EN     = (TIMEOUT_T != '0);

  run_state_t       state, state_next;
  logic [SEL_W-1:0] sel_q;
  logic             load_sel;
  logic             timeout_hit;
  logic             cnt_clear;
  logic             cnt_enable;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      TimedOut <= 1'b0;
    end else begin
      state <= state_next;
      if (load_sel)
        sel_q <= ProgSel;
      if (state_next == ST_ARMED)
        TimedOut <= 1'b0;
      else if (timeout_hit)
        TimedOut <= 1'b1;
    end
  end

  // Priority in RUN: abort (Start) > CoreDone > watchdog.
  always_comb begin
    state_next  = state;
    load_sel    = 1'b0;
    timeout_hit = 1'b0;
    PcLoad      = 1'b0;
    RunEn       = 1'b0;
    Ack         = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (Start) begin
          state_next = ST_ARMED;
          load_sel   = 1'b1;
        end
      end
      ST_ARMED: begin
        PcLoad = 1'b1;
        if (!Start)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        RunEn = 1'b1;
        if (Start) begin
          state_next = ST_ARMED;
          load_sel   = 1'b1;
        end else if (CoreDone) begin
          state_next = ST_DONE;
        end else if (WD_EN && (CycleCount == TO_LAST)) begin
          state_next  = ST_DONE;
          timeout_hit = 1'b1;
        end
      end
      ST_DONE: begin
        Ack = 1'b1;
        if (Start) begin
          state_next = ST_ARMED;
          load_sel   = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign PcLoadVal  = PC_W'(prog_base(32'(sel_q)));
  assign cnt_clear  = (state_next == ST_ARMED);
  assign cnt_enable = (state == ST_RUN);

  cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_counter (
    .Clk      (Clk),
    .Reset    (Reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .saturate (1'b1),
    .count    (CycleCount)
  );

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three instances with TIMEOUT 0, 50, 10
// share one stimulus stream; a vector table plus hand-written sequences.
module tb_run_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [1:0] ProgSel;
  logic       CoreDone;

  logic        pc_load    [3];
  logic [9:0]  pc_val     [3];
  logic        run_en     [3];
  logic        ack        [3];
  logic        timed_out  [3];
  logic [15:0] cyc_cnt    [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  run_sequencer #(.TIMEOUT(0)) u_t0 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .CoreDone(CoreDone),
    .PcLoad(pc_load[0]), .PcLoadVal(pc_val[0]), .RunEn(run_en[0]), .Ack(ack[0]),
    .TimedOut(timed_out[0]), .CycleCount(cyc_cnt[0]));

  run_sequencer #(.TIMEOUT(50)) u_t50 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .CoreDone(CoreDone),
    .PcLoad(pc_load[1]), .PcLoadVal(pc_val[1]), .RunEn(run_en[1]), .Ack(ack[1]),
    .TimedOut(timed_out[1]), .CycleCount(cyc_cnt[1]));

  run_sequencer #(.TIMEOUT(10)) u_t10 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel), .CoreDone(CoreDone),
    .PcLoad(pc_load[2]), .PcLoadVal(pc_val[2]), .RunEn(run_en[2]), .Ack(ack[2]),
    .TimedOut(timed_out[2]), .CycleCount(cyc_cnt[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic        cd;
    logic        pcload;
    logic [9:0]  pcval;
    logic        runen;
    logic        ack;
    logic        to;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic chk_all(input int d, input string tag, input logic pl, input logic [9:0] pv,
                         input logic re, input logic ak, input logic to, input logic [15:0] cn);
    chk({tag, ".PcLoad"},     32'(pc_load[d]),   32'(pl));
    chk({tag, ".PcLoadVal"},  32'(pc_val[d]),    32'(pv));
    chk({tag, ".RunEn"},      32'(run_en[d]),    32'(re));
    chk({tag, ".Ack"},        32'(ack[d]),       32'(ak));
    chk({tag, ".TimedOut"},   32'(timed_out[d]), 32'(to));
    chk({tag, ".CycleCount"}, 32'(cyc_cnt[d]),   32'(cn));
  endtask

  initial begin
    //          start sel cd | pl  val  run ack to cnt
    vecs[0]  = '{1'b0, 2'd0, 1'b1, 1'b0, 10'd0,   1'b0, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 2'd3, 1'b1, 1'b1, 10'd384, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 2'd1, 1'b1, 1'b1, 10'd384, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[3]  = '{1'b0, 2'd1, 1'b0, 1'b0, 10'd384, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[4]  = '{1'b0, 2'd1, 1'b0, 1'b0, 10'd384, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 2'd1, 1'b0, 1'b0, 10'd384, 1'b1, 1'b0, 1'b0, 16'd2};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 1'b0, 10'd384, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[7]  = '{1'b0, 2'd1, 1'b1, 1'b0, 10'd384, 1'b0, 1'b1, 1'b0, 16'd3};
    vecs[8]  = '{1'b1, 2'd2, 1'b1, 1'b1, 10'd256, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 10'd256, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[10] = '{1'b1, 2'd1, 1'b1, 1'b1, 10'd128, 1'b0, 1'b0, 1'b0, 16'd0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 1'b0, 10'd128, 1'b1, 1'b0, 1'b0, 16'd0};

    Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; CoreDone = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) chk_all(d, $sformatf("reset[%0d]", d), 0, 0, 0, 0, 0, 0);
    Reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      Start = vecs[i].start; ProgSel = vecs[i].sel; CoreDone = vecs[i].cd;
      tick();
      chk_all(0, $sformatf("vec%0d", i), vecs[i].pcload, vecs[i].pcval, vecs[i].runen,
              vecs[i].ack, vecs[i].to, vecs[i].cnt);
    end

    // Launch program 2, CoreDone on RUN cycle 20.
    Reset = 1'b1; Start = 1'b0; CoreDone = 1'b0; tick(); Reset = 1'b0;
    Start = 1'b1; ProgSel = 2'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s1.pcload%0d", i), 32'(pc_load[0]), 32'd1);
      chk($sformatf("s1.pcval%0d", i),  32'(pc_val[0]),  32'd256);
    end
    Start = 1'b0; ProgSel = 2'd0;
    tick();
    chk("s1.runen", 32'(run_en[0]), 32'd1);
    for (int i = 0; i < 19; i++) tick();
    CoreDone = 1'b1; tick(); CoreDone = 1'b0;
    chk_all(0, "s1.t0",  0, 10'd256, 0, 1, 0, 16'd20);
    chk_all(1, "s1.t50", 0, 10'd256, 0, 1, 0, 16'd20);
    chk_all(2, "s1.t10", 0, 10'd256, 0, 1, 1, 16'd10);

    // Watchdog at 50 with CoreDone never asserted.
    Start = 1'b1; tick();
    chk("s2.ackdrop", 32'(ack[0]), 32'd0);
    Start = 1'b0; tick();
    for (int i = 0; i < 49; i++) tick();
    chk("s2.t50.run49", 32'(run_en[1]), 32'd1);
    chk("s2.t50.ack49", 32'(ack[1]),    32'd0);
    chk("s2.t50.cnt49", 32'(cyc_cnt[1]), 32'd49);
    tick();
    chk_all(1, "s2.t50", 0, 10'd0, 0, 1, 1, 16'd50);
    chk("s2.t0.cnt", 32'(cyc_cnt[0]), 32'd50);
    chk("s2.t0.run", 32'(run_en[0]),  32'd1);

    // CoreDone coincident with the 10-cycle watchdog.
    Start = 1'b1; tick(); Start = 1'b0; tick();
    for (int i = 0; i < 9; i++) tick();
    CoreDone = 1'b1; tick(); CoreDone = 1'b0;
    chk_all(2, "s3.t10", 0, 10'd0, 0, 1, 0, 16'd10);
    chk("s3.t50.to", 32'(timed_out[1]), 32'd0);

    // Abort at RUN cycle 5 with CoreDone in the same cycle.
    Start = 1'b1; ProgSel = 2'd0; tick(); Start = 1'b0; tick();
    for (int i = 0; i < 4; i++) tick();
    chk("s4.cnt4", 32'(cyc_cnt[0]), 32'd4);
    Start = 1'b1; ProgSel = 2'd1; CoreDone = 1'b1; tick();
    chk_all(0, "s4.abort", 1, 10'd128, 0, 0, 0, 16'd0);
    Start = 1'b0; CoreDone = 1'b0; tick();
    for (int i = 0; i < 3; i++) tick();
    chk("s4.recount", 32'(cyc_cnt[0]), 32'd3);
    chk("s4.pcval",   32'(pc_val[0]),  32'd128);

    // DONE with CoreDone held, then relaunch program 3.
    CoreDone = 1'b1; tick(); tick();
    chk_all(0, "s5.done", 0, 10'd128, 0, 1, 0, 16'd4);
    Start = 1'b1; ProgSel = 2'd3; tick();
    chk_all(0, "s5.armed", 1, 10'd384, 0, 0, 0, 16'd0);
    Start = 1'b0; CoreDone = 1'b0; tick();

    // Reset during RUN cycle 7.
    for (int i = 0; i < 6; i++) tick();
    Reset = 1'b1; tick(); Reset = 1'b0;
    chk_all(0, "s6.reset.t0",  0, 10'd0, 0, 0, 0, 16'd0);
    chk_all(1, "s6.reset.t50", 0, 10'd0, 0, 0, 0, 16'd0);

    // Saturation with the watchdog disabled.
    Start = 1'b1; tick(); Start = 1'b0; tick();
    repeat (65534) tick();
    chk("s6.cnt_fffe", 32'(cyc_cnt[0]), 32'h0000_FFFE);
    repeat (70000 - 65534) tick();
    chk("s6.cnt_sat", 32'(cyc_cnt[0]), 32'h0000_FFFF);
    chk("s6.run_sat", 32'(run_en[0]),  32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Run-control FSM for the single-cycle core. Converts the testbench Start/Ack handshake into core control signals:
  - a PC load of a per-program base address;
  - a run enable that the top level uses to gate instruction fetch to NOP;
  - a registered done acknowledge.
- Also owns the cycle counter and a watchdog timeout.
- Sits between the top-level ports and ProgCtr/Ctrl, replacing ad-hoc ever_start/should_run gating.

Parameters:
- PC_W, 10, program-counter width.
- CNT_W, 16, cycle-counter width.
- SEL_W, 2, program-select width (2**SEL_W programs).
- TIMEOUT, 16'hFFFF, watchdog limit in RUN cycles; 0 disables the watchdog.

Ports:
- Clk  in  1  clock, posedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  testbench start, level; held high ≥1 cycle per launch.
- ProgSel  in  SEL_W  program index; sampled on the first Start-high cycle.
- CoreDone  in  1  done decode from Ctrl; meaningful only while RunEn=1.
- PcLoad  out  1  ProgCtr loads PcLoadVal this cycle.
- PcLoadVal  out  PC_W  base address of the selected program.
- RunEn  out  1  core executes; when 0 the top level forces NOP and RegFile/DataMem write enables are ignored.
- Ack  out  1  program finished (registered).
- TimedOut  out  1  last run ended by watchdog, not CoreDone.
- CycleCount  out  CNT_W  RUN cycles of the current/last run.

Behaviour:
- States: IDLE, ARMED, RUN, DONE. Encoding 2 bits, defined in the package.
- Reset (sync, any state, including mid-run):
  - state=IDLE, PcLoad=0, PcLoadVal=0, RunEn=0, Ack=0, TimedOut=0, CycleCount=0, latched sel=0.
- IDLE:
  - All outputs idle.
  - Start=1 -> ARMED; latch ProgSel in that same edge.
- ARMED:
  - Outputs: PcLoad=1, PcLoadVal=PROG_BASE[latched sel], RunEn=0, Ack=0.
  - CycleCount=0 and TimedOut=0, both cleared on entry.
  - Stays while Start=1. ProgSel changes while Start is held are ignored.
  - Start=0 -> RUN.
- RUN:
  - Outputs: RunEn=1, PcLoad=0.
  - CycleCount increments every RUN cycle, including the cycle CoreDone is high.
  - CoreDone=1 -> DONE; Ack=1 from the next cycle (1-cycle latency).
  - TIMEOUT≠0 and CycleCount==TIMEOUT-1 with CoreDone=0 -> DONE with TimedOut=1.
  - CoreDone and timeout in the same cycle: CoreDone wins, TimedOut=0.
  - Start=1 in RUN aborts -> ARMED (relaunch); latch new ProgSel. Abort has priority over CoreDone.
- DONE:
  - Outputs: Ack=1, RunEn=0, PcLoad=0. CycleCount and TimedOut hold.
  - Start=1 -> ARMED (Ack drops the next cycle); latch ProgSel.
- TIMEOUT=0:
  - Watchdog off.
  - CycleCount saturates at all-ones and never wraps.
- CoreDone is ignored outside RUN.
- Outputs are Moore, decoded from registered state, except PcLoadVal, which comes from the latched sel register.
- Width rule: CycleCount compare is done at CNT_W bits. TIMEOUT is truncated to CNT_W.

Decomposition:
- Package run_seq_pkg:
  - state enum;
  - PROG_BASE array (SEL_W-indexed, PC_W wide; defaults 0, 10'd128, 10'd256, 10'd384);
  - CNT_W/PC_W defaults.
- Sub-module cycle_counter (clear, enable, saturate, CNT_W) is natural and reusable for perf counters.
- FSM and output decode stay in run_sequencer.

Test Plan:
- Reset then Start high 3 cycles with ProgSel=2 -> PcLoad=1 and PcLoadVal=256 for 3 cycles, then RunEn=1; CoreDone after 20 RUN cycles -> Ack=1 the next cycle, CycleCount=20, TimedOut=0.
- TIMEOUT=50, CoreDone never asserted -> Ack=1 after exactly 50 RUN cycles, TimedOut=1, CycleCount=50, RunEn=0.
- CoreDone and timeout coincident (TIMEOUT=10, CoreDone on RUN cycle 10) -> TimedOut=0, CycleCount=10.
- Start pulsed at RUN cycle 5 with ProgSel=1 -> ARMED, PcLoadVal=128, CycleCount=0; next run counts from 0; CoreDone in the same cycle as Start ignored.
- From DONE, Start with ProgSel=3 -> Ack falls next cycle, PcLoadVal=384; CoreDone held high during IDLE/ARMED/DONE has no effect.
- Reset asserted mid-RUN at cycle 7 -> next edge all outputs 0, state IDLE; TIMEOUT=0 run of 70000 cycles -> CycleCount saturates at 16'hFFFF.
